nested_reader: RTL and testbench

// - Read-side companion of the nested 2D address generator. The writer fills tiles of a
//   NUM_TILES-deep tile buffer and pulses wr_tile_done once per completed tile.
// - This block tracks tile credits and replays the same x/y stride pattern as read addresses.
// - Read addresses go out on a valid/ready stream, one pattern pass per credited tile.
// - Sits between the buffer's write-side generator and the read port of the tile SRAM.

---
 rtl/nested_reader.sv | 151 +++++++++++++++
 tb/tb_nested_reader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/nested_reader.sv
// Read-side address generator for a tile buffer: counts tile credits from the
// writer and replays the nested x/y stride pattern once per credited tile.
//
// state | meaning
// IDLE  | no tile in progress; waiting for en and a credit
// RUN   | presenting read addresses for the current tile
module nested_reader #(
  parameter int NUM_TILES  = 2,
  parameter int TILE_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        wr_tile_done,
  input  logic [15:0] offset,
  input  logic [15:0] x_max,
  input  logic [15:0] x_stride,
  input  logic [15:0] y_max,
  input  logic [15:0] y_stride_op,
  output logic [15:0] addr_out,
  output logic        addr_valid,
  input  logic        addr_ready,
  output logic        rd_tile_done,
  output logic [4:0]  credits,
  output logic        overflow
);

  localparam int          TIW  = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam logic [4:0]  NT5  = 5'(NUM_TILES);
  localparam logic [15:0] TW16 = 16'(TILE_WORDS);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [15:0]     r_x_cnt;
  logic [15:0]     r_y_cnt;
  logic [15:0]     r_acc;
  logic [TIW-1:0]  r_tile_idx;
  logic [4:0]      r_credits;
  logic            r_overflow;
  logic            r_rd_done;
  logic [15:0]     r_sh_offset;
  logic [15:0]     r_sh_x_max;
  logic [15:0]     r_sh_x_stride;
  logic [15:0]     r_sh_y_max;
  logic [15:0]     r_sh_y_stride;

  logic [15:0]     w_xm;
  logic [15:0]     w_ym;
  logic            w_x_at_max;
  logic            w_y_at_max;
  logic            w_beat;
  logic            w_last;
  logic [4:0]      w_credits_nxt;
  logic            w_ovf_set;
  logic            w_latch;
  logic [15:0]     w_tile_base;

  // Zero extents behave as one so a tile always has at least one beat.
  assign w_xm       = (r_sh_x_max == 16'd0) ? 16'd1 : r_sh_x_max;
  assign w_ym       = (r_sh_y_max == 16'd0) ? 16'd1 : r_sh_y_max;
  assign w_x_at_max = (r_x_cnt == w_xm - 16'd1);
  assign w_y_at_max = (r_y_cnt == w_ym - 16'd1);
  assign w_beat     = (r_state == S_RUN) && addr_ready;
  assign w_last     = w_beat && w_x_at_max && w_y_at_max;
  assign w_tile_base = {{(16-TIW){1'b0}}, r_tile_idx} * TW16;

  always_comb begin
    w_credits_nxt = r_credits;
    w_ovf_set     = 1'b0;
    if (wr_tile_done && !w_last) begin
      if (r_credits == NT5) w_ovf_set = 1'b1;
      else                  w_credits_nxt = r_credits + 5'd1;
    end else if (!wr_tile_done && w_last) begin
      w_credits_nxt = r_credits - 5'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en && (w_credits_nxt != 5'd0)) begin
          w_state_nxt = S_RUN;
          w_latch     = 1'b1;
        end
      end
      S_RUN: begin
        if (w_last) begin
          if (en && (w_credits_nxt != 5'd0)) w_latch = 1'b1;
          else                               w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_x_cnt       <= 16'd0;
      r_y_cnt       <= 16'd0;
      r_acc         <= 16'd0;
      r_tile_idx    <= '0;
      r_credits     <= 5'd0;
      r_overflow    <= 1'b0;
      r_rd_done     <= 1'b0;
      r_sh_offset   <= 16'd0;
      r_sh_x_max    <= 16'd0;
      r_sh_x_stride <= 16'd0;
      r_sh_y_max    <= 16'd0;
      r_sh_y_stride <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_credits  <= w_credits_nxt;
      r_overflow <= r_overflow | w_ovf_set;
      r_rd_done  <= w_last;
      if (w_latch) begin
        r_sh_offset   <= offset;
        r_sh_x_max    <= x_max;
        r_sh_x_stride <= x_stride;
        r_sh_y_max    <= y_max;
        r_sh_y_stride <= y_stride_op;
      end
      if (w_last) begin
        r_x_cnt    <= 16'd0;
        r_y_cnt    <= 16'd0;
        r_acc      <= 16'd0;
        r_tile_idx <= r_tile_idx + TIW'(1);
      end else if (w_beat) begin
        if (w_x_at_max) begin
          r_x_cnt <= 16'd0;
          r_y_cnt <= w_y_at_max ? 16'd0 : r_y_cnt + 16'd1;
          r_acc   <= r_acc + r_sh_y_stride;
        end else begin
          r_x_cnt <= r_x_cnt + 16'd1;
          r_acc   <= r_acc + r_sh_x_stride;
        end
      end
    end
  end

  assign addr_out     = r_sh_offset + w_tile_base + r_acc;
  assign addr_valid   = (r_state == S_RUN);
  assign rd_tile_done = r_rd_done;
  assign credits      = r_credits;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_nested_reader.sv
// Directed bench for nested_reader: expected addresses go into a scoreboard
// queue, a negedge monitor compares every presented address against its head.
module tb_nested_reader;

  logic        clk;
  logic        reset;
  logic        en;
  logic        wr_tile_done;
  logic [15:0] offset;
  logic [15:0] x_max;
  logic [15:0] x_stride;
  logic [15:0] y_max;
  logic [15:0] y_stride_op;
  logic [15:0] addr_out;
  logic        addr_valid;
  logic        addr_ready;
  logic        rd_tile_done;
  logic [4:0]  credits;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] sb[$];

  nested_reader #(.NUM_TILES(2), .TILE_WORDS(256)) dut (
    .clk(clk), .reset(reset), .en(en), .wr_tile_done(wr_tile_done),
    .offset(offset), .x_max(x_max), .x_stride(x_stride), .y_max(y_max),
    .y_stride_op(y_stride_op), .addr_out(addr_out), .addr_valid(addr_valid),
    .addr_ready(addr_ready), .rd_tile_done(rd_tile_done), .credits(credits),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every presented address must match the scoreboard head.
  always @(negedge clk) begin
    if (!reset && addr_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_addr: got %0h with no expected address queued", addr_out);
      end else begin
        if (addr_out !== sb[0]) begin
          n_bad++;
          $display("FAIL addr_seq: got %0h expected %0h", addr_out, sb[0]);
        end
        if (addr_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; wr_tile_done = 1'b0; addr_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic cfg(input logic [15:0] off, input logic [15:0] xm, input logic [15:0] ym,
                     input logic [15:0] xs, input logic [15:0] ys);
    offset = off; x_max = xm; y_max = ym; x_stride = xs; y_stride_op = ys;
  endtask

  task automatic pulse_wr();
    wr_tile_done = 1'b1;
    tick();
    wr_tile_done = 1'b0;
  endtask

  task automatic push6(input logic [15:0] base);
    sb.push_back(base + 16'h0); sb.push_back(base + 16'h1); sb.push_back(base + 16'h2);
    sb.push_back(base + 16'h7); sb.push_back(base + 16'h8); sb.push_back(base + 16'h9);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || addr_valid) && n < budget) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n >= budget) begin
      n_bad++;
      $display("FAIL %s: drain timeout, %0d addresses left, valid=%0b", name, sb.size(), addr_valid);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; wr_tile_done = 1'b0; addr_ready = 1'b0;
    cfg(16'h0, 16'h0, 16'h0, 16'h0, 16'h0);

    // Test 1: single tile, ready always high
    do_reset();
    chk("rst_addr", addr_out, 0);
    chk("rst_valid", addr_valid, 0);
    chk("rst_rd_done", rd_tile_done, 0);
    chk("rst_credits", credits, 0);
    chk("rst_overflow", overflow, 0);
    cfg(16'h100, 16'd3, 16'd2, 16'd1, 16'd5);
    en = 1'b1; addr_ready = 1'b1;
    push6(16'h100);
    pulse_wr();
    chk("t1_credit_latency", credits, 1);
    chk("t1_valid_latency", addr_valid, 1);
    repeat (6) tick();
    chk("t1_rd_done", rd_tile_done, 1);
    chk("t1_credits_end", credits, 0);
    chk("t1_valid_end", addr_valid, 0);
    chk("t1_sb_empty", sb.size(), 0);

    // Test 2: ready toggling, same pattern in 12 cycles
    do_reset();
    en = 1'b1; addr_ready = 1'b1;
    push6(16'h100);
    pulse_wr();
    for (int i = 0; i < 12; i++) begin
      addr_ready = (i % 2 == 1);
      tick();
    end
    addr_ready = 1'b1;
    chk("t2_rd_done", rd_tile_done, 1);
    chk("t2_valid_end", addr_valid, 0);
    chk("t2_sb_empty", sb.size(), 0);

    // Test 3: two tiles back to back, second at tile base 0x100
    do_reset();
    en = 1'b1; addr_ready = 1'b1;
    push6(16'h100);
    push6(16'h200);
    pulse_wr();
    chk("t3_credits_1", credits, 1);
    pulse_wr();
    chk("t3_credits_2", credits, 2);
    repeat (5) tick();
    chk("t3_rd_done_1", rd_tile_done, 1);
    chk("t3_credits_mid", credits, 1);
    chk("t3_no_bubble", addr_valid, 1);
    chk("t3_tile2_addr", addr_out, 16'h200);
    repeat (6) tick();
    chk("t3_rd_done_2", rd_tile_done, 1);
    chk("t3_credits_end", credits, 0);
    chk("t3_valid_end", addr_valid, 0);

    // Test 4: overflow, then last beat coincident with wr_tile_done
    do_reset();
    addr_ready = 1'b1;
    pulse_wr(); pulse_wr(); pulse_wr();
    chk("t4_credits_full", credits, 2);
    chk("t4_overflow", overflow, 1);
    chk("t4_idle_valid", addr_valid, 0);
    push6(16'h100);
    push6(16'h200);
    push6(16'h100);
    en = 1'b1;
    tick();
    chk("t4_valid", addr_valid, 1);
    repeat (5) tick();
    pulse_wr();
    chk("t4_credits_same", credits, 2);
    chk("t4_overflow_sticky", overflow, 1);
    chk("t4_rd_done", rd_tile_done, 1);
    chk("t4_next_tile", addr_out, 16'h200);
    wait_idle("t4_drain", 40);
    chk("t4_credits_end", credits, 0);

    // Test 5: zero extents give single-beat tiles; x_max change waits for next tile
    do_reset();
    cfg(16'h40, 16'd0, 16'd0, 16'd1, 16'd5);
    en = 1'b1; addr_ready = 1'b1;
    sb.push_back(16'h40);
    sb.push_back(16'h140); sb.push_back(16'h141); sb.push_back(16'h142);
    pulse_wr();
    x_max = 16'd3;
    pulse_wr();
    chk("t5_rd_done", rd_tile_done, 1);
    chk("t5_credits", credits, 1);
    chk("t5_tile1_addr", addr_out, 16'h140);
    wait_idle("t5_drain", 20);
    chk("t5_credits_end", credits, 0);

    // Test 6: reset in the middle of a tile
    do_reset();
    cfg(16'h100, 16'd3, 16'd2, 16'd1, 16'd5);
    addr_ready = 1'b1;
    pulse_wr(); pulse_wr(); pulse_wr();
    chk("t6_overflow_pre", overflow, 1);
    sb.push_back(16'h100); sb.push_back(16'h101);
    en = 1'b1;
    tick(); tick(); tick();
    chk("t6_beat3_addr", addr_out, 16'h102);
    reset = 1'b1;
    tick();
    chk("t6_valid", addr_valid, 0);
    chk("t6_credits", credits, 0);
    chk("t6_overflow", overflow, 0);
    chk("t6_addr", addr_out, 0);
    chk("t6_sb_empty", sb.size(), 0);
    reset = 1'b0;
    en = 1'b0;
    tick(); tick();
    chk("t6_stays_idle", addr_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
